fir_datapath: RTL and testbench
===============================

FIR_DATAPATH -- requirements
Module: fir_datapath

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk sampled on rising edge; n_reset low at a rising edge resets state.
REQ-002 The ports SHALL be:
- clk  input  1  system clock
- n_reset  input  1  synchronous active-low reset
- op  input  2  operation: 00 nop, 01 copy, 10 load, 11 add
- src1  input  4  register index, operand A
- src2  input  4  register index, operand B
- dest  input  4  register index written by op
- ext_data  input  16  sample word written by load
- cnt_up  input  1  sample-count increment strobe
- overflow  output  1  signed add overflow, combinational
- outreg_data  output  16  contents of register 0
- sample_count  output  16  number of processed samples

Function
REQ-003 The block SHALL hold a 16-entry x 16-bit register file, r0..r15, all entries general purpose; index 4'hF SHALL address r15 normally.
REQ-004 The nop op SHALL write nothing.
REQ-005 The copy op SHALL write r[src1] to r[dest] at the next rising edge.
REQ-006 The load op SHALL write ext_data to r[dest] at the next rising edge.
REQ-007 The add op SHALL write the 16-bit two's-complement sum r[src1] + r[src2] to r[dest] at the next rising edge.
REQ-008 Read ports SHALL be combinational; a read of a register written in the same cycle SHALL return the pre-edge value.
REQ-009 The same-cycle case src1 == dest (or src2 == dest) SHALL read the old value and write the new value.
REQ-010 overflow SHALL be 1 only while op == 11 and both operands share a sign bit that differs from the raw sum's sign bit; otherwise 0.
REQ-011 overflow SHALL be valid in the same cycle the add op is presented, with zero latency, so the controller can branch on it in that state.
REQ-012 outreg_data SHALL equal r0 at all times and SHALL update one cycle after any write to r0.
REQ-013 sample_count SHALL increment by 1 at each rising edge with cnt_up == 1.
REQ-014 sample_count SHALL wrap from 16'hFFFF to 16'h0000 without any flag.
REQ-015 A write SHALL complete even when overflow == 1; error handling belongs to the controller.
REQ-016 cnt_up and a register write in the same cycle SHALL both take effect independently.

Reset
REQ-017 When n_reset == 0 at a rising edge, r0..r15 SHALL clear to 16'h0000 and sample_count SHALL clear to 16'h0000; any concurrent op or cnt_up SHALL be ignored.
REQ-018 After reset, outreg_data SHALL read 16'h0000 and overflow SHALL be 0 unless an add op is presented.
REQ-019 Reset asserted mid-sequence (between any two ops) SHALL discard all partial results, with no retained state.

Configuration
REQ-020 The add-saturation feature SHALL be controlled by the macro FIR_DATAPATH_SAT_EN.
- Defined: on an overflowing add, the value written SHALL clamp to 16'h7FFF (positive overflow) or 16'h8000 (negative overflow).
- Undefined: the wrapped 16-bit sum SHALL be written.
- In both builds, overflow SHALL assert identically per REQ-010.

Verification
REQ-021 Load sequence: load ext_data=16'h1234 to r5, then copy r5->r0 -> outreg_data=16'h1234 two cycles after the load op; overflow=0 throughout.
REQ-022 Add, no overflow: r1=16'h0010, r2=16'h0020, add r1+r2->r7 -> r7=16'h0030, overflow=0.
REQ-023 Add, overflow: r1=16'h7FFF, r2=16'h0001, add->r3 -> overflow=1 in the op cycle; r3=16'h8000 without FIR_DATAPATH_SAT_EN, 16'h7FFF with it.
REQ-024 Negative overflow: r1=16'h8000, r2=16'hFFFF, add->r4 -> overflow=1; r4=16'h7FFF without the macro, 16'h8000 with it.
REQ-025 Counter wrap and reset: 65536 cnt_up pulses -> sample_count=16'h0000; then pulse cnt_up with n_reset=0 at the same edge -> sample_count stays 16'h0000.
REQ-026 Read/write collision: r6=16'h0005, add r6+r6->r6 -> the next cycle reads 16'h000A; within the op cycle, the read still returns 16'h0005.

Source files
------------

// File: rtl/fir_datapath.sv
// ---------------------------------------------------------------------------
// fir_datapath
//
// Purpose:
//   Register-file datapath for a small FIR controller. It holds sixteen
//   16-bit general-purpose registers, performs nop/copy/load/add operations
//   into a destination register, reports signed add overflow combinationally,
//   and keeps a free-running sample counter.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   n_reset       in   1   synchronous active-low reset
//   op            in   2   00 nop, 01 copy, 10 load, 11 add
//   src1          in   4   operand A register index
//   src2          in   4   operand B register index
//   dest          in   4   destination register index
//   ext_data      in  16   sample word written by load
//   cnt_up        in   1   sample-count increment strobe
//   overflow      out  1   signed add overflow (combinational)
//   outreg_data   out 16   contents of r0
//   sample_count  out 16   number of processed samples (wraps silently)
//
// Configuration:
//   FIR_DATAPATH_SAT_EN - when defined, an overflowing add writes the
//   saturated value (16'h7FFF / 16'h8000) instead of the wrapped sum.
//   The overflow flag behaves the same way in both builds.
// ---------------------------------------------------------------------------
module fir_datapath (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [1:0]  op,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic [3:0]  dest,
    input  logic [15:0] ext_data,
    input  logic        cnt_up,
    output logic        overflow,
    output logic [15:0] outreg_data,
    output logic [15:0] sample_count
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    logic [15:0] r_regFile [16];
    logic [15:0] r_sampleCount;

    logic [15:0] w_opA;
    logic [15:0] w_opB;
    logic [15:0] w_sum;
    logic        w_addOverflow;
    logic [15:0] w_addResult;
    logic        w_writeEn;
    logic [15:0] w_writeData;

    // Read ports are plain array lookups, so a register written this cycle
    // still shows its pre-edge value until the edge commits the write.
    assign w_opA = r_regFile[src1];
    assign w_opB = r_regFile[src2];
    assign w_sum = w_opA + w_opB;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign w_addOverflow = (w_opA[15] == w_opB[15]) && (w_sum[15] != w_opA[15]);

`ifdef FIR_DATAPATH_SAT_EN
    // Operand A's sign tells which way the add ran off the range.
    assign w_addResult = w_addOverflow ? (w_opA[15] ? 16'h8000 : 16'h7FFF) : w_sum;
`else
    assign w_addResult = w_sum;
`endif

    assign overflow     = (op == OP_ADD) && w_addOverflow;
    assign outreg_data  = r_regFile[0];
    assign sample_count = r_sampleCount;

    // Decode the op into a single write port; nop leaves the file untouched.
    always_comb begin
        w_writeEn   = 1'b0;
        w_writeData = '0;
        case (op)
            OP_NOP: begin
                w_writeEn   = 1'b0;
            end
            OP_COPY: begin
                w_writeEn   = 1'b1;
                w_writeData = w_opA;
            end
            OP_LOAD: begin
                w_writeEn   = 1'b1;
                w_writeData = ext_data;
            end
            OP_ADD: begin
                w_writeEn   = 1'b1;
                w_writeData = w_addResult;
            end
            default: begin
                w_writeEn   = 1'b0;
            end
        endcase
    end

    // Register file: reset clears every entry and masks any concurrent op.
    // Writes go through even when the add overflowed.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regFile[i] <= '0;
            end
        end else if (w_writeEn) begin
            r_regFile[dest] <= w_writeData;
        end
    end

    // Sample counter runs independently of register writes and wraps
    // from 16'hFFFF to zero with no flag.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_sampleCount <= '0;
        end else if (cnt_up) begin
            r_sampleCount <= r_sampleCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_fir_datapath.sv
// ---------------------------------------------------------------------------
// tb_fir_datapath
//
// Purpose:
//   Self-checking bench for fir_datapath. A behavioural model (an array of
//   sixteen words, an integer add with range checks, and a counter) tracks
//   the expected state; registers other than r0 are observed by copying
//   them into r0 and reading outreg_data.
//
// Honors FIR_DATAPATH_SAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_fir_datapath;

    logic        clk;
    logic        n_reset;
    logic [1:0]  op;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic [15:0] ext_data;
    logic        cnt_up;
    logic        overflow;
    logic [15:0] outreg_data;
    logic [15:0] sample_count;

    int checksPassed = 0;
    int checksTotal  = 0;

    logic [15:0] modelRegs [16];
    logic [15:0] modelCount;

    fir_datapath dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .op           (op),
        .src1         (src1),
        .src2         (src2),
        .dest         (dest),
        .ext_data     (ext_data),
        .cnt_up       (cnt_up),
        .overflow     (overflow),
        .outreg_data  (outreg_data),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference add: true integer sum, then range check and clamp or wrap.
    function automatic void modelAdd(input logic [15:0] a, input logic [15:0] b,
                                     output logic [15:0] res, output logic ovf);
        int sa;
        int sb;
        int s;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        s   = sa + sb;
        ovf = (s > 32767) || (s < -32768);
`ifdef FIR_DATAPATH_SAT_EN
        if (s > 32767)
            res = 16'h7FFF;
        else if (s < -32768)
            res = 16'h8000;
        else
            res = 16'(s);
`else
        res = 16'(s);
`endif
    endfunction

    // Expected overflow for whatever is currently on the inputs.
    function automatic logic modelOverflow();
        logic [15:0] res;
        logic        ovf;
        modelAdd(modelRegs[src1], modelRegs[src2], res, ovf);
        return (op == 2'b11) ? ovf : 1'b0;
    endfunction

    // Drive one cycle's inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic [1:0] o, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] d,
                                 input logic [15:0] x, input logic c,
                                 input logic rn);
        op       = o;
        src1     = a;
        src2     = b;
        dest     = d;
        ext_data = x;
        cnt_up   = c;
        n_reset  = rn;
        #1;
    endtask

    // Take the clock edge and advance the model with the same inputs.
    task automatic advanceClock();
        logic [15:0] nextRegs [16];
        logic [15:0] nextCount;
        logic [15:0] res;
        logic        ovf;
        nextRegs  = modelRegs;
        nextCount = modelCount;
        if (!n_reset) begin
            for (int i = 0; i < 16; i++) nextRegs[i] = 16'h0000;
            nextCount = 16'h0000;
        end else begin
            case (op)
                2'b01: nextRegs[dest] = modelRegs[src1];
                2'b10: nextRegs[dest] = ext_data;
                2'b11: begin
                    modelAdd(modelRegs[src1], modelRegs[src2], res, ovf);
                    nextRegs[dest] = res;
                end
                default: ;
            endcase
            if (cnt_up) nextCount = modelCount + 16'd1;
        end
        @(posedge clk);
        #1;
        modelRegs  = nextRegs;
        modelCount = nextCount;
    endtask

    task automatic doOp(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic [15:0] x);
        applyStimulus(o, a, b, d, x, 1'b0, 1'b1);
        advanceClock();
    endtask

    task automatic test_reset();
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd0, 16'hBEEF, 1'b1, 1'b0);
        advanceClock();
        applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);
        checksTotal++;
        if (outreg_data !== 16'h0000)
            $display("[TB] FAIL reset_outreg: got %h expected %h", outreg_data, 16'h0000);
        else checksPassed++;
        checksTotal++;
        if (sample_count !== 16'h0000)
            $display("[TB] FAIL reset_count: got %h expected %h", sample_count, 16'h0000);
        else checksPassed++;
        checksTotal++;
        if (overflow !== 1'b0)
            $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
        else checksPassed++;
    endtask

    task automatic test_load_copy();
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd5, 16'h1234, 1'b0, 1'b1);
        checksTotal++;
        if (overflow !== 1'b0)
            $display("[TB] FAIL load_overflow: got %b expected 0", overflow);
        else checksPassed++;
        advanceClock();
        applyStimulus(2'b01, 4'd5, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);
        checksTotal++;
        if (overflow !== 1'b0 || outreg_data !== 16'h0000)
            $display("[TB] FAIL copy_cycle: got ovf=%b r0=%h expected ovf=0 r0=0000", overflow, outreg_data);
        else checksPassed++;
        advanceClock();
        checksTotal++;
        if (outreg_data !== 16'h1234)
            $display("[TB] FAIL load_copy_r0: got %h expected %h", outreg_data, 16'h1234);
        else checksPassed++;
    endtask

    task automatic test_add_basic();
        doOp(2'b10, 4'd0, 4'd0, 4'd1, 16'h0010);
        doOp(2'b10, 4'd0, 4'd0, 4'd2, 16'h0020);
        applyStimulus(2'b11, 4'd1, 4'd2, 4'd7, 16'h0000, 1'b0, 1'b1);
        checksTotal++;
        if (overflow !== 1'b0)
            $display("[TB] FAIL add_basic_overflow: got %b expected 0", overflow);
        else checksPassed++;
        advanceClock();
        doOp(2'b01, 4'd7, 4'd0, 4'd0, 16'h0000);
        checksTotal++;
        if (outreg_data !== 16'h0030)
            $display("[TB] FAIL add_basic_r7: got %h expected %h", outreg_data, 16'h0030);
        else checksPassed++;
    endtask

    task automatic test_add_overflow();
        logic [15:0] expPos;
        logic [15:0] expNeg;
`ifdef FIR_DATAPATH_SAT_EN
        expPos = 16'h7FFF;
        expNeg = 16'h8000;
`else
        expPos = 16'h8000;
        expNeg = 16'h7FFF;
`endif
        doOp(2'b10, 4'd0, 4'd0, 4'd1, 16'h7FFF);
        doOp(2'b10, 4'd0, 4'd0, 4'd2, 16'h0001);
        applyStimulus(2'b11, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b0, 1'b1);
        checksTotal++;
        if (overflow !== 1'b1)
            $display("[TB] FAIL pos_overflow_flag: got %b expected 1", overflow);
        else checksPassed++;
        advanceClock();
        doOp(2'b01, 4'd3, 4'd0, 4'd0, 16'h0000);
        checksTotal++;
        if (outreg_data !== expPos)
            $display("[TB] FAIL pos_overflow_r3: got %h expected %h", outreg_data, expPos);
        else checksPassed++;

        doOp(2'b10, 4'd0, 4'd0, 4'd1, 16'h8000);
        doOp(2'b10, 4'd0, 4'd0, 4'd2, 16'hFFFF);
        applyStimulus(2'b11, 4'd1, 4'd2, 4'd4, 16'h0000, 1'b0, 1'b1);
        checksTotal++;
        if (overflow !== 1'b1)
            $display("[TB] FAIL neg_overflow_flag: got %b expected 1", overflow);
        else checksPassed++;
        advanceClock();
        doOp(2'b01, 4'd4, 4'd0, 4'd0, 16'h0000);
        checksTotal++;
        if (outreg_data !== expNeg)
            $display("[TB] FAIL neg_overflow_r4: got %h expected %h", outreg_data, expNeg);
        else checksPassed++;

        // Same signs, no overflow: flag must stay low for a negative sum.
        doOp(2'b10, 4'd0, 4'd0, 4'd1, 16'hFFF0);
        applyStimulus(2'b11, 4'd1, 4'd1, 4'd9, 16'h0000, 1'b0, 1'b1);
        checksTotal++;
        if (overflow !== 1'b0)
            $display("[TB] FAIL neg_no_overflow_flag: got %b expected 0", overflow);
        else checksPassed++;
        advanceClock();
    endtask

    task automatic test_collision();
        doOp(2'b10, 4'd0, 4'd0, 4'd6, 16'h0005);
        doOp(2'b11, 4'd6, 4'd6, 4'd6, 16'h0000);
        doOp(2'b01, 4'd6, 4'd0, 4'd0, 16'h0000);
        checksTotal++;
        if (outreg_data !== 16'h000A)
            $display("[TB] FAIL collision_r6: got %h expected %h", outreg_data, 16'h000A);
        else checksPassed++;
        // Same collision on r0, where the pre-edge value is visible.
        doOp(2'b10, 4'd0, 4'd0, 4'd0, 16'h0005);
        applyStimulus(2'b11, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b1);
        checksTotal++;
        if (outreg_data !== 16'h0005)
            $display("[TB] FAIL collision_r0_old: got %h expected %h", outreg_data, 16'h0005);
        else checksPassed++;
        advanceClock();
        checksTotal++;
        if (outreg_data !== 16'h000A)
            $display("[TB] FAIL collision_r0_new: got %h expected %h", outreg_data, 16'h000A);
        else checksPassed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          16'($urandom), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
            checksTotal++;
            if (overflow !== modelOverflow())
                $display("[TB] FAIL random_overflow[%0d]: got %b expected %b", n, overflow, modelOverflow());
            else checksPassed++;
            advanceClock();
            checksTotal++;
            if (outreg_data !== modelRegs[0] || sample_count !== modelCount)
                $display("[TB] FAIL random_state[%0d]: got r0=%h cnt=%h expected r0=%h cnt=%h",
                         n, outreg_data, sample_count, modelRegs[0], modelCount);
            else checksPassed++;
        end
        // Sweep every register out through r0.
        for (int k = 15; k >= 0; k--) begin
            logic [15:0] expVal;
            expVal = modelRegs[k];
            doOp(2'b01, 4'(k), 4'd0, 4'd0, 16'h0000);
            checksTotal++;
            if (outreg_data !== expVal)
                $display("[TB] FAIL random_sweep_r%0d: got %h expected %h", k, outreg_data, expVal);
            else checksPassed++;
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(2'b10, 4'd0, 4'd0, 4'(k), 16'(16'hA000 + k), 1'b1, 1'b1);
            advanceClock();
        end
        applyStimulus(2'b11, 4'd1, 4'd2, 4'd0, 16'h0000, 1'b1, 1'b0);
        advanceClock();
        checksTotal++;
        if (sample_count !== 16'h0000 || outreg_data !== 16'h0000)
            $display("[TB] FAIL mid_reset_clear: got cnt=%h r0=%h expected 0000/0000", sample_count, outreg_data);
        else checksPassed++;
        for (int k = 1; k < 16; k++) begin
            doOp(2'b01, 4'(k), 4'd0, 4'd0, 16'h0000);
            checksTotal++;
            if (outreg_data !== modelRegs[0] || outreg_data !== 16'h0000)
                $display("[TB] FAIL mid_reset_r%0d: got %h expected %h", k, outreg_data, 16'h0000);
            else checksPassed++;
        end
    endtask

    task automatic test_counter_wrap();
        applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0);
        advanceClock();
        for (int n = 0; n < 65535; n++) begin
            applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b1);
            advanceClock();
        end
        checksTotal++;
        if (sample_count !== 16'hFFFF)
            $display("[TB] FAIL count_ffff: got %h expected %h", sample_count, 16'hFFFF);
        else checksPassed++;
        // Concurrent load and count: both take effect.
        applyStimulus(2'b10, 4'd0, 4'd0, 4'd0, 16'h5A5A, 1'b1, 1'b1);
        advanceClock();
        checksTotal++;
        if (sample_count !== 16'h0000 || outreg_data !== 16'h5A5A)
            $display("[TB] FAIL count_wrap: got cnt=%h r0=%h expected 0000/5a5a", sample_count, outreg_data);
        else checksPassed++;
        applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0);
        advanceClock();
        checksTotal++;
        if (sample_count !== 16'h0000 || sample_count !== modelCount)
            $display("[TB] FAIL count_reset_pulse: got %h expected %h", sample_count, 16'h0000);
        else checksPassed++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) modelRegs[i] = 16'hXXXX;
        modelCount = 16'hXXXX;
        op = 2'b00; src1 = '0; src2 = '0; dest = '0;
        ext_data = '0; cnt_up = 1'b0; n_reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_copy();
        test_add_basic();
        test_add_overflow();
        test_collision();
        test_random();
        test_mid_reset();
        test_counter_wrap();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
